sensor_conditioner: RTL and testbench

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/sensor_conditioner.sv | 146 ++++++++++++++
 tb/tb_sensor_conditioner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: conditions the five raw loop detectors of the
// intersection before they reach the light controller. Each lane gets a
// debouncer, an optional demand latch and a sticky stuck-sensor detector.
// Lane order everywhere: bit0 e_str, bit1 w_str, bit2 e_left, bit3 w_left, bit4 ns.
// Optional feature: define SENSOR_LATCH_EN to hold a demand until the lane
// has been served by green. Without it each sensor output is the debounced level.

package light_package;
  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } colors;
endpackage

module sensor_conditioner #(
  parameter int unsigned DEB_CYCLES   = 3,   // 1..15
  parameter int unsigned STUCK_CYCLES = 60   // 2..255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           raw_sensor,
  input  light_package::colors e_str_light,
  input  light_package::colors w_str_light,
  input  light_package::colors e_left_light,
  input  light_package::colors w_left_light,
  input  light_package::colors ns_light,
  output logic                 e_str_sensor,
  output logic                 w_str_sensor,
  output logic                 e_left_sensor,
  output logic                 w_left_sensor,
  output logic                 ns_sensor,
  output logic [4:0]           fault
);
  import light_package::*;

  localparam int unsigned NLANES    = 5;
  localparam logic [4:0]  DEB_LIM   = 5'(DEB_CYCLES);
  localparam logic [7:0]  STUCK_LIM = 8'(STUCK_CYCLES);

  // Per-lane state. The lane FSM (IDLE/PRESENT/WAITING) is carried directly
  // by the (deb, dem) register pair: IDLE = (0,0), PRESENT = (1,1),
  // WAITING = (0,1). No separate state register is needed.
  logic [4:0] deb_q,   deb_d;
  logic [4:0] dem_q,   dem_d;
  logic [4:0] sens_q,  sens_d;
  logic [4:0] fault_q, fault_d;
  logic [3:0] cnt_q  [NLANES];
  logic [3:0] cnt_d  [NLANES];
  logic [7:0] scnt_q [NLANES];
  logic [7:0] scnt_d [NLANES];

  // Debounce: deb follows raw only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    deb_d = deb_q;
    for (int l = 0; l < NLANES; l++) begin
      cnt_d[l] = 4'd0;
      if (raw_sensor[l] != deb_q[l]) begin
        if (({1'b0, cnt_q[l]} + 5'd1) == DEB_LIM) begin
          deb_d[l] = raw_sensor[l];
        end else begin
          cnt_d[l] = cnt_q[l] + 4'd1;
        end
      end
    end
  end

`ifdef SENSOR_LATCH_EN
  colors light [NLANES];
  assign light[0] = e_str_light;
  assign light[1] = w_str_light;
  assign light[2] = e_left_light;
  assign light[3] = w_left_light;
  assign light[4] = ns_light;

  // Demand latch: a debounced presence sets it (and wins), only green clears it.
  always_comb begin
    dem_d = dem_q;
    for (int l = 0; l < NLANES; l++) begin
      if (deb_d[l]) begin
        dem_d[l] = 1'b1;
      end else if (light[l] == GREEN) begin
        dem_d[l] = 1'b0;
      end
    end
  end
`else
  // Without latching the lamp feedback has no effect on the outputs.
  logic unused_lights;
  assign unused_lights = ^{e_str_light, w_str_light, e_left_light,
                           w_left_light, ns_light};
  assign dem_d = '0;
`endif

  // Registered demand: next debounced level OR next latched demand.
  assign sens_d = deb_d | dem_d;

  // Stuck detect: count cycles spent debounced-high, saturate, flag stickily.
  always_comb begin
    fault_d = fault_q;
    for (int l = 0; l < NLANES; l++) begin
      scnt_d[l] = 8'd0;
      if (deb_q[l]) begin
        scnt_d[l] = (scnt_q[l] == STUCK_LIM) ? scnt_q[l] : scnt_q[l] + 8'd1;
      end
      if (scnt_d[l] == STUCK_LIM) begin
        fault_d[l] = 1'b1;
      end
    end
  end

  // State registers; synchronous reset clears every lane completely.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      deb_q   <= '0;
      dem_q   <= '0;
      sens_q  <= '0;
      fault_q <= '0;
      for (int l = 0; l < NLANES; l++) begin
        cnt_q[l]  <= '0;
        scnt_q[l] <= '0;
      end
    end else begin
      deb_q   <= deb_d;
      dem_q   <= dem_d;
      sens_q  <= sens_d;
      fault_q <= fault_d;
      for (int l = 0; l < NLANES; l++) begin
        cnt_q[l]  <= cnt_d[l];
        scnt_q[l] <= scnt_d[l];
      end
    end
  end

  assign e_str_sensor  = sens_q[0];
  assign w_str_sensor  = sens_q[1];
  assign e_left_sensor = sens_q[2];
  assign w_left_sensor = sens_q[3];
  assign ns_sensor     = sens_q[4];
  assign fault         = fault_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: directed scenarios plus randomized traffic compared
// against a history-based reference model of sensor_conditioner.
module tb_sensor_conditioner;
  import light_package::*;

  localparam int DEB   = 3;
  localparam int STUCK = 60;
`ifdef SENSOR_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] raw_sensor;
  colors      e_str_light, w_str_light, e_left_light, w_left_light, ns_light;
  logic       e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor;
  logic [4:0] fault;
  logic [4:0] sens;

  int checks = 0;
  int errors = 0;

  sensor_conditioner #(.DEB_CYCLES(DEB), .STUCK_CYCLES(STUCK)) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_sensor   (raw_sensor),
    .e_str_light  (e_str_light),
    .w_str_light  (w_str_light),
    .e_left_light (e_left_light),
    .w_left_light (w_left_light),
    .ns_light     (ns_light),
    .e_str_sensor (e_str_sensor),
    .w_str_sensor (w_str_sensor),
    .e_left_sensor(e_left_sensor),
    .w_left_sensor(w_left_sensor),
    .ns_sensor    (ns_sensor),
    .fault        (fault)
  );

  assign sens = {ns_sensor, w_left_sensor, e_left_sensor, w_str_sensor, e_str_sensor};

  always #5 clk = ~clk;

  // Reference model: deb flips once the last DEB raw samples all disagree
  // with it; high_run is how long deb has been high; faults are sticky.
  logic [15:0] m_hist [5];
  logic [4:0]  m_deb, m_dem, m_fault;
  int          m_high [5];

  function automatic colors lane_light(int l);
    case (l)
      0:       return e_str_light;
      1:       return w_str_light;
      2:       return e_left_light;
      3:       return w_left_light;
      default: return ns_light;
    endcase
  endfunction

  task automatic model_update();
    bit all_diff;
    if (reset) begin
      m_deb = '0; m_dem = '0; m_fault = '0;
      for (int l = 0; l < 5; l++) begin m_hist[l] = '0; m_high[l] = 0; end
      return;
    end
    for (int l = 0; l < 5; l++) begin
      m_hist[l] = {m_hist[l][14:0], raw_sensor[l]};
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++) if (m_hist[l][k] == m_deb[l]) all_diff = 1'b0;
      if (m_deb[l]) m_high[l]++; else m_high[l] = 0;
      if (m_high[l] >= STUCK) m_fault[l] = 1'b1;
      if (all_diff) m_deb[l] = ~m_deb[l];
      if (LATCH) begin
        if (m_deb[l]) m_dem[l] = 1'b1;
        else if (lane_light(l) == GREEN) m_dem[l] = 1'b0;
      end
    end
  endtask

  // One clock: the model consumes the same inputs the DUT sampled, then
  // outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic all_lights(colors c);
    e_str_light = c; w_str_light = c; e_left_light = c; w_left_light = c; ns_light = c;
  endtask

  task automatic apply_reset();
    raw_sensor = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    raw_sensor = 5'h1f;
    all_lights(RED);
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (sens !== 5'b0) begin errors++; $display("FAIL reset_sens: got %b expected 00000", sens); end
    checks++;
    if (fault !== 5'b0) begin errors++; $display("FAIL reset_fault: got %b expected 00000", fault); end
    reset = 1'b0;
    raw_sensor = '0;
    tick();
  endtask

  // Two-cycle glitch must not pass; afterwards a full DEB period is needed.
  task automatic test_glitch();
    apply_reset();
    all_lights(RED);
    raw_sensor[0] = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      if (t == 3) raw_sensor[0] = 1'b0;
      tick();
      checks++;
      if (e_str_sensor !== 1'b0) begin
        errors++; $display("FAIL glitch_t%0d: got %b expected 0", t, e_str_sensor);
      end
    end
    raw_sensor[0] = 1'b1;
    for (int t = 1; t <= DEB; t++) begin
      tick();
      checks++;
      if (e_str_sensor !== (t == DEB)) begin
        errors++; $display("FAIL glitch_refill_t%0d: got %b expected %b", t, e_str_sensor, t == DEB);
      end
    end
  endtask

  // Held rise on ns appears after exactly DEB edges.
  task automatic test_latency();
    apply_reset();
    all_lights(RED);
    raw_sensor[4] = 1'b1;
    for (int t = 1; t <= DEB + 1; t++) begin
      tick();
      checks++;
      if (ns_sensor !== (t >= DEB)) begin
        errors++; $display("FAIL latency_t%0d: got %b expected %b", t, ns_sensor, t >= DEB);
      end
    end
  endtask

  // e_left: raw high 5 cycles, red 20 cycles, then green.
  task automatic test_latch();
    logic exp;
    apply_reset();
    all_lights(RED);
    for (int t = 1; t <= 22; t++) begin
      raw_sensor[2] = (t <= 5);
      if (t >= 21) e_left_light = GREEN;
      tick();
      if (t < 3)       exp = 1'b0;
      else if (t < 8)  exp = 1'b1;
      else if (t < 21) exp = LATCH;
      else             exp = 1'b0;
      checks++;
      if (e_left_sensor !== exp) begin
        errors++; $display("FAIL latch_t%0d: got %b expected %b", t, e_left_sensor, exp);
      end
    end
  endtask

  // w_str held 70 cycles: fault after edge 63 (rise sampled on edge 1), sticky.
  task automatic test_stuck();
    logic [4:0] exp_f;
    apply_reset();
    all_lights(RED);
    raw_sensor[1] = 1'b1;
    for (int t = 1; t <= 70; t++) begin
      tick();
      exp_f = (t >= DEB + STUCK) ? 5'b00010 : 5'b00000;
      checks++;
      if (fault !== exp_f) begin
        errors++; $display("FAIL stuck_t%0d: got %b expected %b", t, fault, exp_f);
      end
    end
    checks++;
    if (w_str_sensor !== 1'b1) begin
      errors++; $display("FAIL stuck_sensor_driven: got %b expected 1", w_str_sensor);
    end
    raw_sensor[1] = 1'b0;
    w_str_light = GREEN;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if (fault !== 5'b00010 || w_str_sensor !== (t < DEB)) begin
        errors++;
        $display("FAIL stuck_release_t%0d: got fault %b sens %b expected fault 00010 sens %b",
                 t, fault, w_str_sensor, t < DEB);
      end
    end
  endtask

  // w_left: build fault and a pending demand (yellow does not serve it),
  // start a partial debounce, then pulse reset.
  task automatic test_reset_mid();
    apply_reset();
    all_lights(RED);
    w_left_light = YELLOW;
    raw_sensor[3] = 1'b1;
    repeat (66) tick();
    raw_sensor[3] = 1'b0;
    repeat (5) tick();
    checks++;
    if (w_left_sensor !== LATCH || fault[3] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got sens %b fault %b expected sens %b fault 1",
               w_left_sensor, fault[3], LATCH);
    end
    raw_sensor[3] = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (sens !== 5'b0 || fault !== 5'b0) begin
      errors++; $display("FAIL mid_reset: got sens %b fault %b expected 00000 00000", sens, fault);
    end
    for (int t = 1; t <= DEB; t++) begin
      tick();
      checks++;
      if (w_left_sensor !== (t == DEB)) begin
        errors++; $display("FAIL post_reset_t%0d: got %b expected %b", t, w_left_sensor, t == DEB);
      end
    end
  endtask

  // Random raw/light/reset traffic; outputs compared to the model every cycle.
  task automatic test_random();
    int flip_max;
    apply_reset();
    raw_sensor = '0;
    all_lights(RED);
    for (int c = 0; c < 3000; c++) begin
      flip_max = (c < 1500) ? 3 : 40;
      for (int l = 0; l < 5; l++)
        if ($urandom_range(0, flip_max) == 0) raw_sensor[l] = ~raw_sensor[l];
      if ($urandom_range(0, 7) == 0) e_str_light  = colors'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) w_str_light  = colors'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) e_left_light = colors'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) w_left_light = colors'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) ns_light     = colors'($urandom_range(0, 2));
      reset = ($urandom_range(0, 499) == 0);
      tick();
      checks++;
      if (sens !== (m_deb | m_dem) || fault !== m_fault) begin
        errors++;
        $display("FAIL random_c%0d: got sens %b fault %b expected sens %b fault %b",
                 c, sens, fault, m_deb | m_dem, m_fault);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    raw_sensor = '0;
    all_lights(RED);
    test_reset();
    test_glitch();
    test_latency();
    test_latch();
    test_stuck();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
